capture_uploader: RTL and testbench

CAPTURE_UPLOADER -- requirements
Module: capture_uploader

---
 rtl/capture_uploader.sv | 165 ++++++++++++++++
 tb/tb_capture_uploader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_uploader.sv
// capture_uploader
//   Streams the contents of a circular capture RAM to a UART transmitter.
//   When grant_txd rises, 2^ADDR_W bytes are read. Reading starts at
//   start_addr and continues in ascending circular address order. Each byte
//   is presented on a valid/ready handshake. done_txd is raised once the
//   upload finishes. If grant_txd drops before the upload finishes, the
//   block aborts and returns to IDLE.
//
//   Optional feature, macro UPLOAD_CHECKSUM_EN:
//     After the last sample byte, one extra byte is sent. It is the XOR of
//     all sample bytes.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   grant_txd   in   upload permission (level)
//   done_txd    out  upload complete, held until grant_txd drops
//   start_addr  in   [ADDR_W] oldest-sample address, sampled on start cycle
//   ram_addr    out  [ADDR_W] capture RAM read address
//   ram_data    in   [8] capture RAM data, one cycle after ram_addr
//   tx_data     out  [8] byte to UART
//   tx_valid    out  tx_data valid
//   tx_ready    in   UART accepts byte (transfer = tx_valid & tx_ready)
module capture_uploader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              grant_txd,
   output logic              done_txd,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_WAIT_RAM = 3'd2,
      S_SEND     = 3'd3,
      S_DONE     = 3'd4
`ifdef UPLOAD_CHECKSUM_EN
      , S_CKSUM  = 3'd5
`endif
   } state_t;

   // Byte counter value at the transfer of the final sample byte
   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]          tx_data_q, tx_data_d;
`ifdef UPLOAD_CHECKSUM_EN
   logic [7:0]          cksum_q, cksum_d;
`endif
   logic                xfer;
   logic                last_byte;

   assign xfer      = tx_valid & tx_ready;
   assign last_byte = (cnt_q == LAST_CNT);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         ram_addr_q <= '0;
         tx_data_q  <= '0;
`ifdef UPLOAD_CHECKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         ram_addr_q <= ram_addr_d;
         tx_data_q  <= tx_data_d;
`ifdef UPLOAD_CHECKSUM_EN
         cksum_q    <= cksum_d;
`endif
      end
   end

   // Next-state logic; losing grant_txd mid-upload aborts to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (grant_txd) state_d = S_FETCH;
         S_FETCH:    state_d = grant_txd ? S_WAIT_RAM : S_IDLE;
         S_WAIT_RAM: state_d = grant_txd ? S_SEND : S_IDLE;
         S_SEND: begin
            if (!grant_txd) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               if (last_byte) begin
`ifdef UPLOAD_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
`ifdef UPLOAD_CHECKSUM_EN
         S_CKSUM: begin
            if (!grant_txd)  state_d = S_IDLE;
            else if (xfer)   state_d = S_DONE;
         end
`endif
         S_DONE:     if (!grant_txd) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath updates
   always_comb begin
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      ram_addr_d = ram_addr_q;
      tx_data_d  = tx_data_q;
`ifdef UPLOAD_CHECKSUM_EN
      cksum_d    = cksum_q;
`endif
      if (state_q == S_IDLE && grant_txd) begin
         addr_d = start_addr;
         cnt_d  = '0;
`ifdef UPLOAD_CHECKSUM_EN
         cksum_d = '0;
`endif
      end
      if (state_q == S_WAIT_RAM) tx_data_d = ram_data;
      // A transfer on an abort cycle still counts as sent
      if (state_q == S_SEND && xfer) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q + 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
         cksum_d = cksum_q ^ tx_data_q;
         if (state_d == S_CKSUM) tx_data_d = cksum_q ^ tx_data_q;
`endif
      end
      // ram_addr only moves when a fetch is about to start, so it holds
      // its value in every other state
      if (state_d == S_FETCH) ram_addr_d = addr_d;
   end

   // Outputs
   always_comb begin
      tx_valid = (state_q == S_SEND);
`ifdef UPLOAD_CHECKSUM_EN
      if (state_q == S_CKSUM) tx_valid = 1'b1;
`endif
      done_txd = (state_q == S_DONE);
      ram_addr = ram_addr_q;
      tx_data  = tx_data_q;
   end

endmodule

// File: tb/tb_capture_uploader.sv
module tb_capture_uploader;

   localparam int AW = 3;
   localparam int N  = 1 << AW;
`ifdef UPLOAD_CHECKSUM_EN
   localparam int NB      = N + 1;
   localparam int EXP_CYC = 3 * N + 2;
`else
   localparam int NB      = N;
   localparam int EXP_CYC = 3 * N + 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          grant_txd;
   logic          done_txd;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;

   logic [7:0]    mem [N];
   logic [7:0]    got [$];
   logic [7:0]    exp_q [$];

   int   total = 0;
   int   bad   = 0;
   logic prev_valid, prev_ready, done_seen;
   logic [7:0] prev_data;

   capture_uploader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .grant_txd  (grant_txd),
      .done_txd   (done_txd),
      .start_addr (start_addr),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read capture RAM
   always @(posedge clk) ram_data <= mem[ram_addr];

   task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, g, e);
      end
   endtask

   // Reference: the bytes an upload from sa must produce
   task automatic build_exp(input logic [AW-1:0] sa);
      logic [7:0] x;
      x = 8'h00;
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         exp_q.push_back(mem[(int'(sa) + k) % N]);
         x = x ^ mem[(int'(sa) + k) % N];
      end
`ifdef UPLOAD_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // One clock: observe at negedge, then step past the rising edge
   task automatic cyc();
      @(negedge clk);
      if (prev_valid && !prev_ready && grant_txd && rst_n) begin
         chk("stall_valid", {31'd0, tx_valid}, 32'd1);
         chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (done_txd && !done_seen) begin
         done_seen = 1'b1;
         chk("done_after_last", got.size(), exp_q.size());
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
   endtask

   // mode 0: ready always high, 1: random ready, 2: 5-cycle stall on byte 2
   task automatic upload(input logic [AW-1:0] sa, input int mode);
      int n;
      int stall;
      build_exp(sa);
      got.delete();
      prev_valid = 1'b0;
      done_seen  = 1'b0;
      stall      = 0;
      start_addr = sa;
      grant_txd  = 1'b1;
      tx_ready   = 1'b1;
      cyc();
      start_addr = AW'($urandom);
      n = 0;
      while (!done_seen && n < 500) begin
         case (mode)
            1: tx_ready = ($urandom_range(0, 99) < 60);
            2: begin
               if (got.size() == 1 && tx_valid && stall < 5) begin
                  tx_ready = 1'b0;
                  stall++;
               end else begin
                  tx_ready = 1'b1;
               end
            end
            default: tx_ready = 1'b1;
         endcase
         cyc();
         n++;
      end
      chk("done_seen", {31'd0, done_seen}, 32'd1);
      if (mode == 0) chk("cycles", n, EXP_CYC);
      chk("count", got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         chk($sformatf("byte%0d", k), (k < got.size()) ? {24'd0, got[k]} : 32'hFFFF_FFFF,
             {24'd0, exp_q[k]});
      grant_txd = 1'b0;
      @(posedge clk);
      #1;
      chk("done_clear", {31'd0, done_txd}, 32'd0);
      chk("idle_valid", {31'd0, tx_valid}, 32'd0);
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      grant_txd  = 1'b0;
      tx_ready   = 1'b0;
      start_addr = '0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = 8'h00;
      done_seen  = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = 8'(i + 16);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_done", {31'd0, done_txd}, 32'd0);
      chk("rst_txdata", {24'd0, tx_data}, 32'd0);
      chk("rst_ramaddr", {29'd0, ram_addr}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_nogrant", {31'd0, done_txd | tx_valid}, 32'd0);

      // Ascending bytes, then wrap from address 6
      upload(3'd0, 0);
      upload(3'd6, 0);

      // Stall on the second byte
      upload(3'd2, 2);

      // Checksum pattern: one-hot bytes XOR to 0xFF
      for (int i = 0; i < N; i++) mem[i] = 8'(1 << i);
      upload(3'd0, 0);

      // Abort after the third transfer
      fill_random();
      build_exp(3'd5);
      got.delete();
      prev_valid = 1'b0;
      done_seen  = 1'b0;
      start_addr = 3'd5;
      grant_txd  = 1'b1;
      tx_ready   = 1'b1;
      cyc();
      n = 0;
      while (got.size() < 3 && n < 100) begin
         cyc();
         n++;
      end
      grant_txd = 1'b0;
      repeat (4) begin
         cyc();
         chk("abort_valid", {31'd0, tx_valid}, 32'd0);
         chk("abort_done", {31'd0, done_txd}, 32'd0);
      end
      chk("abort_count", got.size(), 3);
      for (int k = 0; k < 3; k++)
         chk($sformatf("abort_byte%0d", k), (k < got.size()) ? {24'd0, got[k]} : 32'hFFFF_FFFF,
             {24'd0, exp_q[k]});
      upload(3'd1, 0);

      // Asynchronous reset while holding a byte in SEND
      fill_random();
      prev_valid = 1'b0;
      start_addr = 3'd3;
      grant_txd  = 1'b1;
      tx_ready   = 1'b0;
      cyc();
      n = 0;
      while (!tx_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("async_rst_done", {31'd0, done_txd}, 32'd0);
      chk("async_rst_txdata", {24'd0, tx_data}, 32'd0);
      grant_txd = 1'b0;
      #2 rst_n = 1'b1;
      prev_valid = 1'b0;
      repeat (2) cyc();
      chk("post_rst_idle", {31'd0, tx_valid | done_txd}, 32'd0);
      upload(3'd4, 0);

      // Randomized uploads with random backpressure
      repeat (4) begin
         fill_random();
         upload(AW'($urandom), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
